// File: rtl/control_pkg.sv
// Shared definitions for the control FSM: opcodes, states, bus and ALU encodings.
package control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_LDR  = 5'h01;
  localparam logic [4:0] OP_STR  = 5'h02;
  localparam logic [4:0] OP_LPT  = 5'h03;
  localparam logic [4:0] OP_SPT  = 5'h04;
  localparam logic [4:0] OP_CMP  = 5'h05;
  localparam logic [4:0] OP_ADD  = 5'h06;
  localparam logic [4:0] OP_SUB  = 5'h07;
  localparam logic [4:0] OP_MUL  = 5'h08;
  localparam logic [4:0] OP_DIV  = 5'h09;
  localparam logic [4:0] OP_MOD  = 5'h0A;
  localparam logic [4:0] OP_AND  = 5'h0B;
  localparam logic [4:0] OP_OR   = 5'h0C;
  localparam logic [4:0] OP_XOR  = 5'h0D;
  localparam logic [4:0] OP_NOT  = 5'h0E;
  localparam logic [4:0] OP_LSL  = 5'h0F;
  localparam logic [4:0] OP_LSR  = 5'h10;
  localparam logic [4:0] OP_JMP  = 5'h14;
  localparam logic [4:0] OP_JZ   = 5'h15;
  localparam logic [4:0] OP_JC   = 5'h16;
  localparam logic [4:0] OP_JEQ  = 5'h17;
  localparam logic [4:0] OP_CALL = 5'h18;
  localparam logic [4:0] OP_RET  = 5'h19;
  localparam logic [4:0] OP_HLT  = 5'h1F;

  localparam logic [3:0] BUS_IDLE  = 4'd0;
  localparam logic [3:0] BUS_REG   = 4'd1;
  localparam logic [3:0] BUS_LOAD  = 4'd2;
  localparam logic [3:0] BUS_STORE = 4'd3;
  localparam logic [3:0] BUS_IMM   = 4'd6;

  // Bit 5 marks an active ALU operation; low bits select the function.
  localparam logic [5:0] ALU_NONE = 6'h00;
  localparam logic [5:0] ALU_ADD  = 6'h21;
  localparam logic [5:0] ALU_SUB  = 6'h22;
  localparam logic [5:0] ALU_MUL  = 6'h23;
  localparam logic [5:0] ALU_DIV  = 6'h24;
  localparam logic [5:0] ALU_MOD  = 6'h25;
  localparam logic [5:0] ALU_AND  = 6'h26;
  localparam logic [5:0] ALU_OR   = 6'h27;
  localparam logic [5:0] ALU_XOR  = 6'h28;
  localparam logic [5:0] ALU_NOT  = 6'h29;
  localparam logic [5:0] ALU_LSL  = 6'h2A;
  localparam logic [5:0] ALU_LSR  = 6'h2B;
  localparam logic [5:0] ALU_CMP  = 6'h2C;

  typedef struct packed {
    logic [5:0] alu_op;
    logic [3:0] alu_params;
    logic [3:0] bus_state;
    logic       alu_read_bus;
    logic       ram_write;
    logic [2:0] operand1;
    logic [2:0] operand2;
    logic [2:0] results;
  } ctrl_t;

  function automatic logic [5:0] alu_op_of(input logic [4:0] opc);
    logic [5:0] op;
    case (opc)
      OP_ADD:  op = ALU_ADD;
      OP_SUB:  op = ALU_SUB;
      OP_MUL:  op = ALU_MUL;
      OP_DIV:  op = ALU_DIV;
      OP_MOD:  op = ALU_MOD;
      OP_AND:  op = ALU_AND;
      OP_OR:   op = ALU_OR;
      OP_XOR:  op = ALU_XOR;
      OP_NOT:  op = ALU_NOT;
      OP_LSL:  op = ALU_LSL;
      OP_LSR:  op = ALU_LSR;
      OP_CMP:  op = ALU_CMP;
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/call_stack.sv
// Return-address LIFO; push on full and pop on empty are ignored.
module call_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW:0]   sp_q;
  logic [PW-1:0] top_idx_s;

  assign full_o    = (sp_q == (PW+1)'(DEPTH));
  assign empty_o   = (sp_q == '0);
  assign top_idx_s = sp_q[PW-1:0] - PW'(1);
  assign top_o     = mem_q[top_idx_s];

  // Stack pointer: counts occupied entries.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      sp_q <= sp_q + (PW+1)'(1);
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - (PW+1)'(1);
    end else begin
      sp_q <= sp_q;
    end
  end

  // Entry storage, deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[sp_q[PW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Fetch/execute control sequencer: decodes the latched instruction into
// registered datapath controls and steers the program counter.
module control_fsm
  import control_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned PC_W        = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [15+DATA_W:0]  instr,
  input  logic                instr_valid,
  input  logic [DATA_W-1:0]   hreg,
  input  logic [2:0]          alu_flags,
  output logic [PC_W-1:0]     pc,
  output logic [2:0]          operand1,
  output logic [2:0]          operand2,
  output logic [2:0]          results,
  output logic [5:0]          alu_op,
  output logic [3:0]          alu_params,
  output logic [3:0]          bus_state,
  output logic                alu_read_bus,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_add,
  output logic [DATA_W-1:0]   dout,
  output logic                halted,
  output logic                fault
);

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [4:0]          ir_opc_q;
  logic [DATA_W-1:0]   ir_word2_q;
  ctrl_t               ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   ram_add_q, ram_add_d;
  logic                ram_add_load_d;
  logic                halted_q, fault_q;

  logic [4:0]          opc_s;
  logic [1:0]          opvar_s;
  logic [DATA_W-1:0]   word2_s;
  logic [PC_W-1:0]     pc_inc_s, target_s, stk_top_s;
  logic                take_s, stk_push_s, stk_pop_s, stk_full_s, stk_empty_s;

  assign opc_s    = instr[6:2];
  assign opvar_s  = instr[1:0];
  assign word2_s  = instr[15+DATA_W:16];
  assign pc_inc_s = pc_q + PC_W'(1);
  assign target_s = ir_word2_q[PC_W-1:0];

  assign stk_push_s = (state_q == ST_EXEC) && (ir_opc_q == OP_CALL) && !stk_full_s;
  assign stk_pop_s  = (state_q == ST_EXEC) && (ir_opc_q == OP_RET) && !stk_empty_s;

  call_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_call_stack (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (stk_push_s),
    .pop_i   (stk_pop_s),
    .din_i   (pc_inc_s),
    .top_o   (stk_top_s),
    .full_o  (stk_full_s),
    .empty_o (stk_empty_s)
  );

  // Decode the incoming word so controls appear registered in the EXEC cycle.
  always_comb begin
    ctrl_d         = '0;
    ram_add_d      = '0;
    ram_add_load_d = 1'b0;
    if ((opc_s >= OP_LDR) && (opc_s <= OP_LSR)) begin
      ctrl_d.operand1 = instr[9:7];
      ctrl_d.operand2 = instr[12:10];
      ctrl_d.results  = instr[15:13];
      case (opc_s)
        OP_LDR, OP_LPT: begin
          ctrl_d.bus_state    = BUS_LOAD;
          ctrl_d.alu_read_bus = 1'b1;
        end
        OP_STR, OP_SPT: begin
          ctrl_d.bus_state = BUS_STORE;
          ctrl_d.ram_write = 1'b1;
        end
        default: begin
          ctrl_d.alu_op     = alu_op_of(opc_s);
          ctrl_d.alu_params = {2'b00, opvar_s};
          if (opvar_s[1]) begin
            ctrl_d.bus_state    = BUS_IMM;
            ctrl_d.alu_read_bus = 1'b1;
          end else begin
            ctrl_d.bus_state    = BUS_REG;
            ctrl_d.alu_read_bus = 1'b0;
          end
        end
      endcase
    end else begin
      ctrl_d = '0;
    end
    case (opc_s)
      OP_LDR, OP_STR: begin
        ram_add_load_d = 1'b1;
        ram_add_d      = word2_s;
      end
      OP_LPT, OP_SPT: begin
        ram_add_load_d = 1'b1;
        ram_add_d      = hreg;
      end
      default: begin
        ram_add_load_d = 1'b0;
        ram_add_d      = '0;
      end
    endcase
  end

  // Branch condition from the flags present during EXEC.
  always_comb begin
    take_s = 1'b0;
    case (ir_opc_q)
      OP_JMP:  take_s = 1'b1;
      OP_JZ:   take_s = alu_flags[1];
      OP_JC:   take_s = alu_flags[0];
      OP_JEQ:  take_s = alu_flags[2];
      default: take_s = 1'b0;
    endcase
  end

  // Main sequencer with registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_FETCH;
      pc_q       <= '0;
      ir_opc_q   <= '0;
      ir_word2_q <= '0;
      ctrl_q     <= '0;
      ram_add_q  <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (instr_valid) begin
            ir_opc_q   <= opc_s;
            ir_word2_q <= word2_s;
            ctrl_q     <= ctrl_d;
            state_q    <= ST_EXEC;
            if (ram_add_load_d) begin
              ram_add_q <= ram_add_d;
            end
          end
        end
        ST_EXEC: begin
          case (ir_opc_q)
            OP_LDR, OP_LPT: begin
              pc_q    <= pc_inc_s;
              state_q <= ST_MEM;
            end
            OP_CALL: begin
              ctrl_q <= '0;
              if (stk_full_s) begin
                fault_q <= 1'b1;
                state_q <= ST_FAULT;
              end else begin
                pc_q    <= target_s;
                state_q <= ST_FETCH;
              end
            end
            OP_RET: begin
              ctrl_q <= '0;
              if (stk_empty_s) begin
                fault_q <= 1'b1;
                state_q <= ST_FAULT;
              end else begin
                pc_q    <= stk_top_s;
                state_q <= ST_FETCH;
              end
            end
            OP_HLT: begin
              ctrl_q   <= '0;
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end
            default: begin
              ctrl_q  <= '0;
              pc_q    <= take_s ? target_s : pc_inc_s;
              state_q <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          ctrl_q  <= '0;
          state_q <= ST_FETCH;
        end
        ST_HALT, ST_FAULT: begin
          state_q <= state_q;
        end
        default: begin
          ctrl_q  <= '0;
          fault_q <= 1'b1;
          state_q <= ST_FAULT;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign operand1     = ctrl_q.operand1;
  assign operand2     = ctrl_q.operand2;
  assign results      = ctrl_q.results;
  assign alu_op       = ctrl_q.alu_op;
  assign alu_params   = ctrl_q.alu_params;
  assign bus_state    = ctrl_q.bus_state;
  assign alu_read_bus = ctrl_q.alu_read_bus;
  assign ram_write    = ctrl_q.ram_write;
  assign ram_add      = ram_add_q;
  assign dout         = ir_word2_q;
  assign halted       = halted_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm (shallow stack so overflow is reachable).
module tb_control_fsm;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        instr_valid = 1'b0;
  logic [15:0] hreg = 16'h0;
  logic [2:0]  alu_flags = 3'b000;
  logic [15:0] pc;
  logic [2:0]  operand1, operand2, results;
  logic [5:0]  alu_op;
  logic [3:0]  alu_params, bus_state;
  logic        alu_read_bus, ram_write, halted, fault;
  logic [15:0] ram_add, dout;

  int n_checks = 0;
  int n_errs   = 0;

  control_fsm #(.DATA_W(16), .PC_W(16), .STACK_DEPTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .instr(instr), .instr_valid(instr_valid),
    .hreg(hreg), .alu_flags(alu_flags), .pc(pc), .operand1(operand1),
    .operand2(operand2), .results(results), .alu_op(alu_op),
    .alu_params(alu_params), .bus_state(bus_state), .alu_read_bus(alu_read_bus),
    .ram_write(ram_write), .ram_add(ram_add), .dout(dout),
    .halted(halted), .fault(fault)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [1:0] ov,
                                     input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] r, input logic [15:0] w2);
    return {w2, r, b, a, opc, ov};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Present one word in FETCH; returns 1 ns into the EXEC cycle.
  task automatic issue(input logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge CLK);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic reset_dut();
    RST_N       = 1'b0;
    instr_valid = 1'b0;
    step(2);
    RST_N       = 1'b1;
  endtask

  initial begin
    reset_dut();
    check("rst_pc", pc, 32'h0);
    check("rst_alu_op", alu_op, 32'h0);
    check("rst_bus", bus_state, 32'h0);
    check("rst_ram_write", ram_write, 32'h0);
    check("rst_ram_add", ram_add, 32'h0);
    check("rst_halted", halted, 32'h0);
    check("rst_fault", fault, 32'h0);
    check("rst_dout", dout, 32'h0);

    issue(mk(5'h06, 2'b10, 3'd0, 3'd0, 3'd1, 16'h0005));
    check("addi_alu_op", alu_op, 32'h21);
    check("addi_bus", bus_state, 32'h6);
    check("addi_read_bus", alu_read_bus, 32'h1);
    check("addi_results", results, 32'h1);
    check("addi_dout", dout, 32'h5);
    check("addi_pc_exec", pc, 32'h0);
    step(1);
    check("addi_pc_after", pc, 32'h1);
    check("addi_alu_op_idle", alu_op, 32'h0);
    check("addi_read_bus_idle", alu_read_bus, 32'h0);

    step(3);
    check("wait_pc", pc, 32'h1);
    check("wait_bus", bus_state, 32'h0);
    check("wait_ram_write", ram_write, 32'h0);

    issue(mk(5'h02, 2'b00, 3'd2, 3'd0, 3'd0, 16'h0400));
    check("str_ram_write", ram_write, 32'h1);
    check("str_ram_add", ram_add, 32'h400);
    check("str_operand1", operand1, 32'h2);
    step(1);
    check("str_ram_write_off", ram_write, 32'h0);
    check("str_ram_add_hold", ram_add, 32'h400);
    check("str_pc", pc, 32'h2);

    issue(mk(5'h07, 2'b00, 3'd3, 3'd4, 3'd5, 16'h0000));
    check("sub_bus_reg", bus_state, 32'h1);
    check("sub_read_bus", alu_read_bus, 32'h0);
    check("sub_operand2", operand2, 32'h4);
    step(1);
    check("sub_pc", pc, 32'h3);

    alu_flags = 3'b010;
    issue(mk(5'h15, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0040));
    step(1);
    check("jz_taken", pc, 32'h40);
    alu_flags = 3'b101;
    issue(mk(5'h15, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0080));
    step(1);
    check("jz_not_taken", pc, 32'h41);
    alu_flags = 3'b100;
    issue(mk(5'h17, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0010));
    step(1);
    check("jeq_taken", pc, 32'h10);
    alu_flags = 3'b000;

    issue(mk(5'h18, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0100));
    step(1);
    check("call_pc", pc, 32'h100);
    issue(mk(5'h19, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000));
    step(1);
    check("ret_pc", pc, 32'h11);

    hreg = 16'h1234;
    issue(mk(5'h03, 2'b00, 3'd0, 3'd0, 3'd6, 16'h0000));
    check("lpt_bus", bus_state, 32'h2);
    check("lpt_ram_add", ram_add, 32'h1234);
    check("lpt_ram_write", ram_write, 32'h0);
    step(1);
    check("lpt_mem_read_bus", alu_read_bus, 32'h1);
    check("lpt_mem_bus", bus_state, 32'h2);
    check("lpt_pc", pc, 32'h12);
    step(1);
    check("lpt_done_read_bus", alu_read_bus, 32'h0);

    issue(mk(5'h12, 2'b10, 3'd1, 3'd1, 3'd1, 16'h0000));
    check("unimpl_alu_op", alu_op, 32'h0);
    check("unimpl_bus", bus_state, 32'h0);
    step(1);
    check("unimpl_pc", pc, 32'h13);

    issue(mk(5'h14, 2'b00, 3'd0, 3'd0, 3'd0, 16'hFFFF));
    step(1);
    check("jmp_pc", pc, 32'hFFFF);
    issue(mk(5'h00, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000));
    step(1);
    check("pc_wrap", pc, 32'h0);

    alu_flags = 3'b001;
    issue(mk(5'h16, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0005));
    step(1);
    check("jc_taken", pc, 32'h5);
    alu_flags = 3'b000;
    issue(mk(5'h16, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0009));
    step(1);
    check("jc_not_taken", pc, 32'h6);

    issue(mk(5'h18, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0200));
    step(1);
    issue(mk(5'h18, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0300));
    step(1);
    check("call2_pc", pc, 32'h300);
    issue(mk(5'h18, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0400));
    step(1);
    check("ovf_fault", fault, 32'h1);
    check("ovf_pc_hold", pc, 32'h300);
    instr       = mk(5'h06, 2'b10, 3'd0, 3'd0, 3'd1, 16'h0005);
    instr_valid = 1'b1;
    step(3);
    instr_valid = 1'b0;
    check("fault_terminal_pc", pc, 32'h300);
    check("fault_terminal_alu_op", alu_op, 32'h0);
    check("fault_sticky", fault, 32'h1);

    reset_dut();
    check("rst_clears_fault", fault, 32'h0);
    issue(mk(5'h19, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000));
    step(1);
    check("ret_empty_fault", fault, 32'h1);
    check("ret_empty_pc", pc, 32'h0);

    reset_dut();
    issue(mk(5'h18, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0200));
    step(1);
    issue(mk(5'h18, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0300));
    step(1);
    issue(mk(5'h19, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000));
    step(1);
    check("lifo_ret1", pc, 32'h201);
    issue(mk(5'h19, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000));
    step(1);
    check("lifo_ret2", pc, 32'h1);
    check("lifo_no_fault", fault, 32'h0);

    issue(mk(5'h1F, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000));
    step(1);
    check("hlt_halted", halted, 32'h1);
    instr       = mk(5'h06, 2'b10, 3'd0, 3'd0, 3'd1, 16'h0005);
    instr_valid = 1'b1;
    step(2);
    instr_valid = 1'b0;
    check("halt_terminal_alu_op", alu_op, 32'h0);
    check("halt_sticky", halted, 32'h1);

    reset_dut();
    check("rst_clears_halt", halted, 32'h0);
    issue(mk(5'h01, 2'b00, 3'd0, 3'd0, 3'd4, 16'h0777));
    check("ldr_ram_add", ram_add, 32'h777);
    check("ldr_read_bus", alu_read_bus, 32'h1);
    step(1);
    check("ldr_mem_read_bus", alu_read_bus, 32'h1);
    RST_N = 1'b0;
    step(1);
    RST_N = 1'b1;
    check("mem_rst_pc", pc, 32'h0);
    check("mem_rst_read_bus", alu_read_bus, 32'h0);
    check("mem_rst_bus", bus_state, 32'h0);
    check("mem_rst_ram_add", ram_add, 32'h0);
    issue(mk(5'h06, 2'b10, 3'd0, 3'd0, 3'd1, 16'h0005));
    check("post_rst_fetch", alu_op, 32'h21);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
